// File: rtl/line_win_pkg.sv
// rtl/line_win_pkg.sv - shared types, codes and line-mask helper for the board win scanner
package line_win_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;

  // Upper bound on board size so the mask helper can return a fixed-width vector.
  localparam int MAX_N  = 8;
  localparam int MASK_W = MAX_N * MAX_N;

  function automatic int num_lines(input int n);
    return 2 * n + 2;
  endfunction

  function automatic int idx_width(input int n);
    return $clog2(2 * n + 2);
  endfunction

  // Cell (r,c) with r=0 top, c=0 left lives at bit n*n-1-(r*n+c).
  function automatic logic [MASK_W-1:0] line_mask(input int n, input int idx);
    logic [MASK_W-1:0] m;
    logic              on;
    m = '0;
    for (int r = 0; r < MAX_N; r++) begin
      for (int c = 0; c < MAX_N; c++) begin
        on = 1'b0;
        if (r < n && c < n) begin
          if (idx < n)           on = (r == idx);
          else if (idx < 2 * n)  on = (c == idx - n);
          else if (idx == 2 * n) on = (r == c);
          else                   on = (r + c == n - 1);
        end
        if (on) m = m | (MASK_W'(1) << (n * n - 1 - (r * n + c)));
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/line_mask_gen.sv
// rtl/line_mask_gen.sv - combinational line index to N*N cell mask
module line_mask_gen
  import line_win_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [idx_width(N)-1:0] idx,
  output logic [N*N-1:0]          mask
);

  logic [MASK_W-1:0] full_mask;
  logic              unused_mask_bits;

  always_comb begin
    full_mask        = line_mask(N, int'(idx));
    mask             = full_mask[N*N-1:0];
    unused_mask_bits = ^full_mask;
  end

endmodule

// File: rtl/line_win_scanner.sv
// rtl/line_win_scanner.sv - sequential N x N win/draw/conflict scanner, one line per cycle
module line_win_scanner
  import line_win_pkg::*;
#(
  parameter int N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N*N-1:0]   ain,
  input  logic [N*N-1:0]   bin,
  output logic             busy,
  output logic             done,
  output logic [2*N+1:0]   win_line,
  output logic [1:0]       winner,
  output logic             draw,
  output logic             conflict
);

  localparam int L  = num_lines(N);
  localparam int IW = idx_width(N);
  localparam int C  = N * N;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            drain_q, drain_d;
  logic [C-1:0]    a_q, a_d, b_q, b_d;
  logic            a_any_q, a_any_d, b_any_q, b_any_d;
  logic [IW-1:0]   a_first_q, a_first_d, b_first_q, b_first_d;
  logic [L-1:0]    win_line_q, win_line_d;
  logic [1:0]      winner_q, winner_d;
  logic            draw_q, draw_d;
  logic            conflict_q, conflict_d;

  logic [C-1:0]    mask;
  logic            a_hit, b_hit;

  line_mask_gen #(.N(N)) u_mask (
    .idx  (idx_q),
    .mask (mask)
  );

  assign a_hit = ((a_q & mask) == mask);
  assign b_hit = ((b_q & mask) == mask);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    drain_d    = drain_q;
    a_d        = a_q;
    b_d        = b_q;
    a_any_d    = a_any_q;
    b_any_d    = b_any_q;
    a_first_d  = a_first_q;
    b_first_d  = b_first_q;
    win_line_d = win_line_q;
    winner_d   = winner_q;
    draw_d     = draw_q;
    conflict_d = conflict_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = ain;
          b_d       = bin;
          a_any_d   = 1'b0;
          b_any_d   = 1'b0;
          a_first_d = '0;
          b_first_d = '0;
          idx_d     = '0;
          drain_d   = 1'b0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        // After the last line is tested one extra cycle folds the hit registers into the results.
        if (drain_q) begin
          state_d    = REPORT;
          conflict_d = (|(a_q & b_q)) | (a_any_q & b_any_q);
          if (a_any_q) begin
            win_line_d = L'(1) << a_first_q;
            winner_d   = WIN_A;
          end else if (b_any_q) begin
            win_line_d = L'(1) << b_first_q;
            winner_d   = WIN_B;
          end else begin
            win_line_d = '0;
            winner_d   = WIN_NONE;
          end
          draw_d = (&(a_q | b_q)) & ~a_any_q & ~b_any_q & ~conflict_d;
        end else begin
          if (a_hit && !a_any_q) begin
            a_any_d   = 1'b1;
            a_first_d = idx_q;
          end
          if (b_hit && !b_any_q) begin
            b_any_d   = 1'b1;
            b_first_d = idx_q;
          end
          if (idx_q == IW'(L - 1)) drain_d = 1'b1;
          else                     idx_d   = idx_q + 1'b1;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      drain_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      a_any_q    <= 1'b0;
      b_any_q    <= 1'b0;
      a_first_q  <= '0;
      b_first_q  <= '0;
      win_line_q <= '0;
      winner_q   <= WIN_NONE;
      draw_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      drain_q    <= drain_d;
      a_q        <= a_d;
      b_q        <= b_d;
      a_any_q    <= a_any_d;
      b_any_q    <= b_any_d;
      a_first_q  <= a_first_d;
      b_first_q  <= b_first_d;
      win_line_q <= win_line_d;
      winner_q   <= winner_d;
      draw_q     <= draw_d;
      conflict_q <= conflict_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == REPORT);
  assign win_line = win_line_q;
  assign winner   = winner_q;
  assign draw     = draw_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_line_win_scanner.sv
// tb/tb_line_win_scanner.sv - self-checking bench for line_win_scanner (N=3 and N=4 instances)
module tb_line_win_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start3, start4;
  logic [8:0]  ain3, bin3;
  logic [15:0] ain4, bin4;
  logic        busy3, done3, draw3, conflict3;
  logic        busy4, done4, draw4, conflict4;
  logic [7:0]  wl3;
  logic [9:0]  wl4;
  logic [1:0]  winner3, winner4;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  line_win_scanner #(.N(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .ain(ain3), .bin(bin3),
    .busy(busy3), .done(done3), .win_line(wl3), .winner(winner3),
    .draw(draw3), .conflict(conflict3)
  );

  line_win_scanner #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .ain(ain4), .bin(bin4),
    .busy(busy4), .done(done4), .win_line(wl4), .winner(winner4),
    .draw(draw4), .conflict(conflict4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk every line as a list of (row,col) cells and decide ownership directly.
  task automatic model(input int n, input logic [15:0] a, input logic [15:0] b,
                       output logic [9:0] wl, output logic [1:0] w,
                       output logic dr, output logic cf);
    int   a_line, b_line, r, c;
    logic a_own, b_own, full;
    logic [15:0] all_cells;
    a_line = -1;
    b_line = -1;
    r = 0;
    c = 0;
    for (int i = 0; i < 2 * n + 2; i++) begin
      a_own = 1'b1;
      b_own = 1'b1;
      for (int k = 0; k < n; k++) begin
        if (i < n)           begin r = i;         c = k;     end
        else if (i < 2 * n)  begin r = k;         c = i - n; end
        else if (i == 2 * n) begin r = k;         c = k;     end
        else                 begin r = n - 1 - k; c = k;     end
        a_own = a_own & a[n * n - 1 - (r * n + c)];
        b_own = b_own & b[n * n - 1 - (r * n + c)];
      end
      if (a_own && a_line < 0) a_line = i;
      if (b_own && b_line < 0) b_line = i;
    end
    all_cells = 16'((32'd1 << (n * n)) - 32'd1);
    full = ((a | b) & all_cells) == all_cells;
    cf   = (|(a & b)) || (a_line >= 0 && b_line >= 0);
    wl   = '0;
    w    = 2'b00;
    if (a_line >= 0) begin
      wl[a_line] = 1'b1;
      w = 2'b01;
    end else if (b_line >= 0) begin
      wl[b_line] = 1'b1;
      w = 2'b10;
    end
    dr = full && a_line < 0 && b_line < 0 && !cf;
  endtask

  task automatic run(input int n, input logic [15:0] a, input logic [15:0] b,
                     input bit repulse, input string tag);
    logic [9:0] ewl;
    logic [1:0] ew;
    logic       edr, ecf, got;
    int         cnt, extra;
    model(n, a, b, ewl, ew, edr, ecf);
    @(negedge clk);
    if (n == 3) begin ain3 = a[8:0]; bin3 = b[8:0]; start3 = 1'b1; end
    else        begin ain4 = a;      bin4 = b;      start4 = 1'b1; end
    @(posedge clk);
    #1;
    start3 = 1'b0;
    start4 = 1'b0;
    ain3 = 9'($urandom);
    bin3 = 9'($urandom);
    ain4 = 16'($urandom);
    bin4 = 16'($urandom);
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 40) begin
      @(posedge clk);
      cnt++;
      #1;
      if (repulse && cnt == 3) begin
        if (n == 3) start3 = 1'b1; else start4 = 1'b1;
      end else begin
        start3 = 1'b0;
        start4 = 1'b0;
      end
      got = (n == 3) ? done3 : done4;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'(2 * n + 3));
    chk({tag, "_win_line"}, 32'((n == 3) ? {2'b00, wl3} : wl4), 32'(ewl));
    chk({tag, "_winner"}, 32'((n == 3) ? winner3 : winner4), 32'(ew));
    chk({tag, "_draw"}, 32'((n == 3) ? draw3 : draw4), 32'(edr));
    chk({tag, "_conflict"}, 32'((n == 3) ? conflict3 : conflict4), 32'(ecf));
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'((n == 3) ? done3 : done4), 32'd0);
    chk({tag, "_idle"}, 32'((n == 3) ? busy3 : busy4), 32'd0);
    if (repulse) begin
      extra = 0;
      for (int i = 0; i < 14; i++) begin
        @(posedge clk);
        #1;
        if ((n == 3) ? done3 : done4) extra++;
      end
      chk({tag, "_no_second_done"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          seen;
    rst_n  = 1'b0;
    start3 = 1'b0;
    start4 = 1'b0;
    ain3 = '0; bin3 = '0; ain4 = '0; bin4 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'({busy3, busy4}), 32'd0);
    chk("reset_done", 32'({done3, done4}), 32'd0);
    chk("reset_win_line", 32'({wl3, wl4}), 32'd0);
    chk("reset_flags", 32'({winner3, winner4, draw3, draw4, conflict3, conflict4}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(3, 16'h01C0, 16'h0000, 1'b0, "row0_a");
    run(3, 16'h0000, 16'h0054, 1'b0, "updiag_b");
    run(3, 16'h0007, 16'h01C0, 1'b0, "both_win");
    run(3, 16'h0163, 16'h009C, 1'b0, "draw");
    run(3, 16'h0001, 16'h0001, 1'b0, "overlap");

    // Results from the overlap board must persist while a new scan runs, then reset aborts it.
    @(negedge clk);
    ain3 = 9'h1C0; bin3 = 9'h000; start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_conflict", 32'(conflict3), 32'd1);
    chk("hold_busy", 32'(busy3), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({busy3, done3, wl3, winner3, draw3, conflict3}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done3 || busy3) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run(3, 16'h0124, 16'h0000, 1'b0, "after_abort");

    run(3, 16'h0000, 16'h0092, 1'b1, "repulse");

    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom_range(0, 511));
      rb = 16'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) rb = rb & ~ra;
      run(3, ra, rb, 1'b0, $sformatf("rand3_%0d", i));
    end

    run(4, 16'h000F, 16'h0000, 1'b0, "n4_row3");
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom) & ~ra;
      run(4, ra, rb, 1'b0, $sformatf("rand4_%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
